// File: rtl/mulmod_pkg.sv
// Shared constants for the Barrett modular multiplier: default modulus, default
// constant multiplicand, pipeline depth and the Barrett reciprocal computation.
package mulmod_pkg;

  localparam int Q_DEFAULT       = 3329;
  localparam int K_CONST_DEFAULT = 3303;
  localparam int NUM_STAGES      = 4;

  // floor(2^(2*data_w) / q); evaluated at elaboration time only.
  function automatic longint unsigned calc_mu(input int data_w, input longint unsigned q);
    return (64'd1 << (2 * data_w)) / q;
  endfunction

endpackage

// File: rtl/dff_en.sv
// Generic pipeline register: synchronous active-low clear and load enable.
module dff_en #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/barrett_mulmod_pipe.sv
// Four-stage Barrett modular multiplier: out_data = in_a * (in_b | K_CONST) mod Q,
// with a tag sideband, a single global stall and an in-flight occupancy counter.
module barrett_mulmod_pipe
  import mulmod_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int Q       = Q_DEFAULT,
  parameter int K_CONST = K_CONST_DEFAULT,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [2:0]        occ
);

  localparam int PW   = 2 * DATA_W;
  localparam int TW   = 2 * DATA_W + 2;
  localparam int RW   = DATA_W + 2;
  localparam int S1_W = 1 + TAG_W + PW;
  localparam int S2_W = 1 + TAG_W + PW + TW;
  localparam int S3_W = 1 + TAG_W + RW;
  localparam int S4_W = 1 + TAG_W + DATA_W;

  localparam logic [TW-1:0] MU  = TW'(calc_mu(DATA_W, longint'(Q)));
  localparam logic [TW-1:0] Q_T = TW'(Q);
  localparam logic [RW-1:0] Q_R = RW'(Q);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high. All stages share one enable, so bubbles advance exactly like data.
  logic w_en;
  logic w_in_xfer;
  logic w_out_xfer;

  assign w_en       = !out_valid || out_ready;
  assign in_ready   = w_en;
  assign w_in_xfer  = in_valid && w_en;
  assign w_out_xfer = out_valid && out_ready;

  // Stage 1: full product P = A * M.
  logic [DATA_W-1:0] w_m;
  logic [PW-1:0]     w_p;
  logic [S1_W-1:0]   r_s1;
  logic              w_v1;
  logic [TAG_W-1:0]  w_tag1;
  logic [PW-1:0]     w_p1;

  assign w_m = in_mode ? DATA_W'(K_CONST) : in_b;
  assign w_p = PW'(in_a) * PW'(w_m);

  dff_en #(.W(S1_W)) u_s1 (
    .clk(clk), .rst(rst), .i_en(w_en), .i_d({in_valid, in_tag, w_p}), .o_q(r_s1)
  );
  assign {w_v1, w_tag1, w_p1} = r_s1;

  // Stage 2: quotient estimate T = (P >> (DATA_W-1)) * MU; P rides along.
  logic [TW-1:0]     w_t;
  logic [S2_W-1:0]   r_s2;
  logic              w_v2;
  logic [TAG_W-1:0]  w_tag2;
  logic [PW-1:0]     w_p2;
  logic [TW-1:0]     w_t2;

  assign w_t = TW'(w_p1 >> (DATA_W - 1)) * MU;

  dff_en #(.W(S2_W)) u_s2 (
    .clk(clk), .rst(rst), .i_en(w_en), .i_d({w_v1, w_tag1, w_p1, w_t}), .o_q(r_s2)
  );
  assign {w_v2, w_tag2, w_p2, w_t2} = r_s2;

  // Stage 3: the estimate never exceeds the true quotient, so R lies in [0, 3Q).
  logic [TW-1:0]     w_qq;
  logic [RW-1:0]     w_r;
  logic [S3_W-1:0]   r_s3;
  logic              w_v3;
  logic [TAG_W-1:0]  w_tag3;
  logic [RW-1:0]     w_r3;

  assign w_qq = TW'(w_t2 >> (DATA_W + 1)) * Q_T;
  assign w_r  = RW'(TW'(w_p2) - w_qq);

  dff_en #(.W(S3_W)) u_s3 (
    .clk(clk), .rst(rst), .i_en(w_en), .i_d({w_v2, w_tag2, w_r}), .o_q(r_s3)
  );
  assign {w_v3, w_tag3, w_r3} = r_s3;

  // Stage 4: two conditional subtractions bring R into [0, Q).
  logic [RW-1:0]     w_r1;
  logic [DATA_W-1:0] w_red;
  logic [S4_W-1:0]   r_s4;

  assign w_r1  = (w_r3 >= Q_R) ? (w_r3 - Q_R) : w_r3;
  assign w_red = (w_r1 >= Q_R) ? DATA_W'(w_r1 - Q_R) : DATA_W'(w_r1);

  dff_en #(.W(S4_W)) u_s4 (
    .clk(clk), .rst(rst), .i_en(w_en), .i_d({w_v3, w_tag3, w_red}), .o_q(r_s4)
  );
  assign {out_valid, out_tag, out_data} = r_s4;

  // Occupancy only moves when exactly one side transfers.
  logic [2:0] w_occ_nxt;
  logic [2:0] r_occ;

  assign w_occ_nxt = w_in_xfer ? (r_occ + 3'd1) : (r_occ - 3'd1);

  dff_en #(.W(3)) u_occ (
    .clk(clk), .rst(rst), .i_en(w_in_xfer ^ w_out_xfer), .i_d(w_occ_nxt), .o_q(r_occ)
  );
  assign occ = r_occ;

endmodule

// File: tb/tb_barrett_mulmod_pipe.sv
// Scoreboard bench for barrett_mulmod_pipe: directed vectors, streaming,
// backpressure, random stalls and mid-flight reset against an integer model.
module tb_barrett_mulmod_pipe;
  import mulmod_pkg::*;

  localparam int DATA_W  = 12;
  localparam int TAG_W   = 4;
  localparam int Q       = 3329;
  localparam int K_CONST = 3303;
  localparam int EW      = TAG_W + DATA_W;
  localparam int N_STREAM = 1000;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_mode = 1'b0;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] in_a = '0;
  logic [DATA_W-1:0] in_b = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [2:0]        occ;

  always #5 clk = ~clk;

  barrett_mulmod_pipe #(
    .DATA_W(DATA_W), .Q(Q), .K_CONST(K_CONST), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .occ(occ)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_in = 0;
  int n_out = 0;
  int n_dropped = 0;
  int first_in_cyc = 0;
  int last_out_cyc = 0;
  bit mark_first = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] golden(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic mode);
    longint m;
    longint p;
    m = mode ? longint'(K_CONST) : longint'(b);
    p = longint'(a) * m;
    return DATA_W'(p % longint'(Q));
  endfunction

  // Monitor: samples on the falling edge the handshakes of the coming rising edge.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        n_dropped += exp_q.size();
        exp_q.delete();
      end else begin
        chk("occ", 32'(occ), 32'(exp_q.size()));
        chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out", 32'(out_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", 32'(out_data), 32'(e[DATA_W-1:0]));
            chk("out_tag", 32'(out_tag), 32'(e[EW-1:DATA_W]));
            n_out++;
            last_out_cyc = cyc;
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back({in_tag, golden(in_a, in_b, in_mode)});
          n_in++;
          if (mark_first) begin
            first_in_cyc = cyc;
            mark_first = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic mode, input logic [TAG_W-1:0] tag);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_mode = mode;
    in_tag = tag;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    chk("drive_accept", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic directed(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic mode, input logic [TAG_W-1:0] tag,
                          input logic [DATA_W-1:0] want);
    int lat;
    drive(a, b, mode, tag);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(NUM_STAGES));
    chk("dir_data", 32'(out_data), 32'(want));
    chk("dir_tag", 32'(out_tag), 32'(tag));
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [EW-1:0] held;
    bit done;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);

    directed(12'd3328, 12'd3328, 1'b0, 4'd1, 12'd1);
    directed(12'd4095, 12'd4095, 1'b0, 4'd2, 12'd852);
    directed(12'd2,    12'd0,    1'b1, 4'd3, 12'd3277);
    directed(12'd3328, 12'd4095, 1'b1, 4'd4, 12'd26);
    directed(12'd0,    12'd4095, 1'b0, 4'd5, 12'd0);
    directed(12'd3329, 12'd7,    1'b0, 4'd6, 12'd0);

    // Back-to-back streaming with mixed modes and tags.
    mark_first = 1'b1;
    for (int i = 0; i < N_STREAM; i++) begin
      drive(DATA_W'($urandom_range(0, 4095)), DATA_W'($urandom_range(0, 4095)),
            1'($urandom_range(0, 1)), TAG_W'(i));
    end
    drain();
    chk("stream_span", 32'(last_out_cyc - first_in_cyc), 32'(N_STREAM - 1 + NUM_STAGES));
    chk("stream_balance", 32'(n_out), 32'(n_in));

    // Backpressure with the pipeline full.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(DATA_W'($urandom_range(0, 4095)), DATA_W'($urandom_range(0, 4095)),
            1'(i), TAG_W'(8 + i));
    end
    in_valid = 1'b0;
    held = exp_q[0];
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_occ", 32'(occ), 32'd4);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_data), 32'(held[DATA_W-1:0]));
      chk("bp_hold_tag", 32'(out_tag), 32'(held[EW-1:DATA_W]));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();
    chk("bp_balance", 32'(n_out), 32'(n_in));

    // Random input gaps and random output stalls.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 2) != 0)
            drive(DATA_W'($urandom_range(0, 4095)), DATA_W'($urandom_range(0, 4095)),
                  1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 15)));
          else
            idle(1);
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("stall_balance", 32'(n_out), 32'(n_in));

    // Reset with three transactions in flight.
    drive(12'd100, 12'd200, 1'b0, 4'd13);
    drive(12'd300, 12'd0,   1'b1, 4'd14);
    drive(12'd4000, 12'd3999, 1'b0, 4'd15);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_occ", 32'(occ), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("no_stale", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    directed(12'd3328, 12'd3328, 1'b0, 4'd7, 12'd1);
    drain();
    chk("final_balance", 32'(n_out + n_dropped), 32'(n_in));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
